hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_scoreboard_mdu_busy_ctr.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the hazard scoreboard slice.
//   HZ_TW       - default width of the Tuse/Tnew timing fields
//   HZ_MULT_LAT - default busy cycles for mult/multu
//   HZ_DIV_LAT  - default busy cycles for div/divu
//   HZ_NREG     - default number of architectural registers
//   HZ_AW       - register address width for HZ_NREG registers
package hazard_pkg;

    localparam int HZ_TW       = 3;
    localparam int HZ_MULT_LAT = 5;
    localparam int HZ_DIV_LAT  = 10;
    localparam int HZ_NREG     = 32;
    localparam int HZ_AW       = $clog2(HZ_NREG);

endpackage

// File: rtl/hazard_scoreboard_mdu_busy_ctr.sv
// mdu_busy_ctr: countdown that models the multiply/divide unit occupancy.
// A load starts a MULT_LAT or DIV_LAT countdown, and a new load restarts it.
// Otherwise the count falls by one per cycle until it reaches zero.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset, abandons any running operation
//   load   - an MDU start instruction issues this cycle
//   is_div - the starting instruction is a divide (selects DIV_LAT)
//   busy   - count is nonzero
module mdu_busy_ctr
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = HZ_MULT_LAT,
    parameter int DIV_LAT  = HZ_DIV_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MW      = $clog2(MAX_LAT + 1);

    logic [MW-1:0] mcnt_r;

    // MDU countdown: load has priority over decrement; saturates at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt_r <= {MW{1'b0}};
        end else if (load) begin
            if (is_div) begin
                mcnt_r <= MW'(DIV_LAT);
            end else begin
                mcnt_r <= MW'(MULT_LAT);
            end
        end else if (mcnt_r != {MW{1'b0}}) begin
            mcnt_r <= mcnt_r - MW'(1);
        end else begin
            mcnt_r <= mcnt_r;
        end
    end

    assign busy = (mcnt_r != {MW{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage interlock for a pipelined MIPS-style core.
// Each register holds a countdown of cycles until its newest pending value
// becomes forwardable. A D-stage source stalls when that countdown exceeds
// the cycles left before the operand is consumed (Tuse). A separate MDU
// countdown stalls any instruction that starts or accesses HI/LO while the
// MDU is busy.
// Optional feature: define HAZARD_SB_STATS_EN to add a 32-bit stall_cycles
// counter output that counts stalled cycles.
// Ports:
//   clk, reset                 - clock; synchronous active-high reset
//   d_valid                    - D stage holds a real instruction
//   d_rs, d_rt                 - D source register addresses
//   d_tuse_rs, d_tuse_rt       - cycles until each operand is consumed
//   d_wr_reg, d_tnew           - destination and cycles until forwardable
//   d_md, d_md_div, d_mf, d_mt - MDU start / divide / HI-LO read / write
//   d_kill                     - flush; the D instruction does not issue
//   stall, stall_rs, stall_rt, stall_mdu - overall stall and its causes
//   mdu_busy                   - MDU countdown is nonzero
//   stall_cycles               - (HAZARD_SB_STATS_EN only) stalled-cycle count
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = HZ_NREG,
    parameter int TW       = HZ_TW,
    parameter int MULT_LAT = HZ_MULT_LAT,
    parameter int DIV_LAT  = HZ_DIV_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_valid,
    input  logic [$clog2(NREG)-1:0] d_rs,
    input  logic [$clog2(NREG)-1:0] d_rt,
    input  logic [TW-1:0]           d_tuse_rs,
    input  logic [TW-1:0]           d_tuse_rt,
    input  logic [$clog2(NREG)-1:0] d_wr_reg,
    input  logic [TW-1:0]           d_tnew,
    input  logic                    d_md,
    input  logic                    d_md_div,
    input  logic                    d_mf,
    input  logic                    d_mt,
    input  logic                    d_kill,
    output logic                    stall,
    output logic                    stall_rs,
    output logic                    stall_rt,
    output logic                    stall_mdu,
    output logic                    mdu_busy
`ifdef HAZARD_SB_STATS_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam int AW = $clog2(NREG);

    logic [TW-1:0] cnt_r [NREG];
    logic          issue_s;
    logic          mdu_load_s;
    logic          mdu_busy_s;

    // Stall decode from current countdown state; zero latency to the pipeline
    always_comb begin
        stall_rs  = 1'b0;
        stall_rt  = 1'b0;
        stall_mdu = 1'b0;
        if (d_valid && (d_rs != {AW{1'b0}}) && (cnt_r[d_rs] > d_tuse_rs)) begin
            stall_rs = 1'b1;
        end else begin
            stall_rs = 1'b0;
        end
        if (d_valid && (d_rt != {AW{1'b0}}) && (cnt_r[d_rt] > d_tuse_rt)) begin
            stall_rt = 1'b1;
        end else begin
            stall_rt = 1'b0;
        end
        if (d_valid && (d_md || d_mf || d_mt) && mdu_busy_s) begin
            stall_mdu = 1'b1;
        end else begin
            stall_mdu = 1'b0;
        end
    end

    assign stall      = stall_rs | stall_rt | stall_mdu;
    // Kill blocks issue but never contributes to stall.
    assign issue_s    = d_valid & ~stall & ~d_kill;
    assign mdu_load_s = issue_s & d_md;
    assign mdu_busy   = mdu_busy_s;

    // Per-register countdown: the newest writer reloads, others count down; $0 pinned to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= {TW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i == 0) begin
                    cnt_r[i] <= {TW{1'b0}};
                end else if (issue_s && (d_wr_reg == AW'(i))) begin
                    cnt_r[i] <= d_tnew;
                end else if (cnt_r[i] != {TW{1'b0}}) begin
                    cnt_r[i] <= cnt_r[i] - TW'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    mdu_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_mdu_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .load   (mdu_load_s),
        .is_div (d_md_div),
        .busy   (mdu_busy_s)
    );

`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_cycles_r;

    // Stalled-cycle statistic; wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
        end else if (stall) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
`endif

endmodule
